// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard and operand unit.
// Tracks one latency counter per architectural register so that dependents
// stall until the producer's result can be forwarded or read from the
// register file. Fixed-latency producers count down. Variable-latency
// producers park at the all-ones value until a completion strobe clears them.
//
// Handshake: an instruction leaves ID on a rising edge where
// issue_fire = issue_valid & ~stall & ~hold. issue_valid may be held high
// across stall cycles, and the bench/pipeline must keep the instruction
// stable until issue_fire is seen.
module id_hazard_scoreboard #(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int LAT_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [NUM_RD-1:0]         re,
    input  logic [NUM_RD*REG_AW-1:0]  rs_addr,
    input  logic [NUM_RD*XLEN-1:0]    rf_data,
    input  logic [NUM_RD*XLEN-1:0]    imm,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      comp_valid,
    input  logic [REG_AW-1:0]         comp_rd,
    output logic [NUM_RD*XLEN-1:0]    opv,
    output logic [NUM_RD-1:0]         rd_hazard,
    output logic                      stall,
    output logic                      issue_fire,
    output logic [REG_AW:0]           outstanding
);

    localparam int               NREG    = 2 ** REG_AW;
    localparam logic [LAT_W-1:0] LAT_VAR = '1;

    // Per-register bubbles remaining; LAT_VAR means "until completion".
    logic [LAT_W-1:0] cnt [NREG];

    logic [NUM_RD-1:0] haz_raw;
    logic              waw_raw;
    logic              stall_raw;
    logic              issue_set;
    logic              issue_var;
    logic              comp_hit;

    // Raw hazards from the registered scoreboard only; same-cycle
    // completions are deliberately not bypassed into stall.
    always_comb begin
        haz_raw = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [REG_AW-1:0] a;
            a = rs_addr[i*REG_AW +: REG_AW];
            haz_raw[i] = re[i] && (a != '0) && (cnt[a] != '0);
        end
        waw_raw   = issue_valid && issue_we && (issue_rd != '0) && (cnt[issue_rd] != '0);
        stall_raw = (|haz_raw) || waw_raw;
    end

    // Externally visible control, forced quiet while in reset.
    always_comb begin
        rd_hazard  = rst ? '0 : haz_raw;
        stall      = !rst && stall_raw;
        issue_fire = !rst && issue_valid && !stall_raw && !hold;
        issue_set  = issue_fire && issue_we && (issue_rd != '0) && (issue_lat != '0);
        issue_var  = issue_set && (issue_lat == LAT_VAR);
        comp_hit   = comp_valid && (comp_rd != '0) && (cnt[comp_rd] == LAT_VAR);
    end

    // Operand select per port: immediate, x0, youngest matching forward, regfile.
    always_comb begin
        opv = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [REG_AW-1:0] a;
            logic [XLEN-1:0]   v;
            logic              hit;
            a   = rs_addr[i*REG_AW +: REG_AW];
            v   = rf_data[i*XLEN +: XLEN];
            hit = 1'b0;
            for (int j = 0; j < NUM_FWD; j++) begin
                if (!hit && fwd_we[j] && (fwd_waddr[j*REG_AW +: REG_AW] == a)) begin
                    v   = fwd_wdata[j*XLEN +: XLEN];
                    hit = 1'b1;
                end
            end
            if (!re[i]) begin
                v = imm[i*XLEN +: XLEN];
            end else if (a == '0) begin
                v = '0;
            end
            opv[i*XLEN +: XLEN] = rst ? '0 : v;
        end
    end

    // Scoreboard update: issue load, completion clear, then countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue_set && (issue_rd == REG_AW'(r))) begin
                    cnt[r] <= issue_lat;
                end else if (comp_hit && (comp_rd == REG_AW'(r))) begin
                    cnt[r] <= '0;
                end else if (!hold && (cnt[r] != '0) && (cnt[r] != LAT_VAR)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // Count of variable-latency entries still waiting for completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (issue_var && !comp_hit) begin
            outstanding <= outstanding + 1'b1;
        end else if (!issue_var && comp_hit) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed testbench for id_hazard_scoreboard.
module tb_id_hazard_scoreboard;

    localparam int NUM_RD  = 2;
    localparam int NUM_FWD = 2;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int LAT_W   = 3;

    logic                      clk;
    logic                      rst;
    logic                      hold;
    logic [NUM_RD-1:0]         re;
    logic [NUM_RD*REG_AW-1:0]  rs_addr;
    logic [NUM_RD*XLEN-1:0]    rf_data;
    logic [NUM_RD*XLEN-1:0]    imm;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD*REG_AW-1:0] fwd_waddr;
    logic [NUM_FWD*XLEN-1:0]   fwd_wdata;
    logic                      issue_valid;
    logic                      issue_we;
    logic [REG_AW-1:0]         issue_rd;
    logic [LAT_W-1:0]          issue_lat;
    logic                      comp_valid;
    logic [REG_AW-1:0]         comp_rd;
    logic [NUM_RD*XLEN-1:0]    opv;
    logic [NUM_RD-1:0]         rd_hazard;
    logic                      stall;
    logic                      issue_fire;
    logic [REG_AW:0]           outstanding;

    int tests_run;
    int tests_failed;

    id_hazard_scoreboard #(
        .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .XLEN(XLEN), .REG_AW(REG_AW), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .re(re), .rs_addr(rs_addr),
        .rf_data(rf_data), .imm(imm), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .comp_valid(comp_valid),
        .comp_rd(comp_rd), .opv(opv), .rd_hazard(rd_hazard), .stall(stall),
        .issue_fire(issue_fire), .outstanding(outstanding)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hold        = 1'b0;
        re          = '0;
        rs_addr     = '0;
        rf_data     = '0;
        imm         = '0;
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        comp_valid  = 1'b0;
        comp_rd     = '0;
    endtask

    task automatic drive_issue(input logic [REG_AW-1:0] rd, input logic [LAT_W-1:0] lat);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
        issue_lat   = lat;
    endtask

    task automatic drop_issue();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
    endtask

    // Tests
    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive_issue(5'd9, 3'd7);
        #1;
        tests_run++;
        if (issue_fire !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_issue_fire: got %b want 1", issue_fire);
        end
        step();
        drop_issue();
        #1;
        tests_run++;
        if (outstanding !== 6'd1) begin
            tests_failed++;
            $display("FAIL reset_pre_outstanding: got %0d want 1", outstanding);
        end
        // Assert reset with a dependent on the pending x9: outputs forced quiet.
        rst     = 1'b1;
        re      = 2'b01;
        rs_addr = {5'd0, 5'd9};
        rf_data = {32'h0, 32'h7777_7777};
        issue_valid = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0 || rd_hazard !== 2'b00 || issue_fire !== 1'b0 || opv !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_forced: got stall=%b haz=%b fire=%b opv=%h want 0 0 0 0",
                     stall, rd_hazard, issue_fire, opv);
        end
        issue_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0 || outstanding !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_cleared: got stall=%b outst=%0d want 0 0", stall, outstanding);
        end
        rs_addr   = {5'd0, 5'd0};
        fwd_we    = 2'b01;
        fwd_waddr = {5'd0, 5'd0};
        fwd_wdata = {32'h0, 32'hDEAD_BEEF};
        #1;
        tests_run++;
        if (opv[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_operand: got %h want 00000000", opv[31:0]);
        end
    endtask

    task automatic test_load_use();
        idle();
        drive_issue(5'd5, 3'd1);
        #1;
        tests_run++;
        if (issue_fire !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_issue_fire: got %b want 1", issue_fire);
        end
        step();
        drop_issue();
        re      = 2'b10;
        rs_addr = {5'd5, 5'd0};
        rf_data = {32'h9999_9999, 32'h0};
        #1;
        tests_run++;
        if (stall !== 1'b1 || rd_hazard !== 2'b10) begin
            tests_failed++;
            $display("FAIL lu_stall: got stall=%b haz=%b want 1 10", stall, rd_hazard);
        end
        step();
        tests_run++;
        if (stall !== 1'b0 || rd_hazard !== 2'b00) begin
            tests_failed++;
            $display("FAIL lu_release: got stall=%b haz=%b want 0 00", stall, rd_hazard);
        end
        fwd_we    = 2'b10;
        fwd_waddr = {5'd5, 5'd0};
        fwd_wdata = {32'h0000_1234, 32'h0};
        #1;
        tests_run++;
        if (opv[63:32] !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL lu_fwd1: got %h want 00001234", opv[63:32]);
        end
    endtask

    task automatic test_forward_priority();
        idle();
        re        = 2'b01;
        rs_addr   = {5'd0, 5'd7};
        rf_data   = {32'h0, 32'h0000_00CC};
        imm       = {32'h0, 32'h0000_0055};
        fwd_we    = 2'b11;
        fwd_waddr = {5'd7, 5'd7};
        fwd_wdata = {32'h0000_000B, 32'h0000_000A};
        #1;
        tests_run++;
        if (opv[31:0] !== 32'h0000_000A) begin
            tests_failed++;
            $display("FAIL fwd_youngest: got %h want 0000000a", opv[31:0]);
        end
        fwd_we = 2'b10;
        #1;
        tests_run++;
        if (opv[31:0] !== 32'h0000_000B) begin
            tests_failed++;
            $display("FAIL fwd_older: got %h want 0000000b", opv[31:0]);
        end
        fwd_we = 2'b00;
        #1;
        tests_run++;
        if (opv[31:0] !== 32'h0000_00CC) begin
            tests_failed++;
            $display("FAIL fwd_none_rf: got %h want 000000cc", opv[31:0]);
        end
        fwd_we = 2'b11;
        re     = 2'b00;
        #1;
        tests_run++;
        if (opv[31:0] !== 32'h0000_0055) begin
            tests_failed++;
            $display("FAIL imm_select: got %h want 00000055", opv[31:0]);
        end
    endtask

    task automatic test_variable();
        int stall_cycles;
        idle();
        drive_issue(5'd9, 3'd7);
        step();
        drop_issue();
        re      = 2'b01;
        rs_addr = {5'd0, 5'd9};
        #1;
        tests_run++;
        if (outstanding !== 6'd1) begin
            tests_failed++;
            $display("FAIL var_outstanding: got %0d want 1", outstanding);
        end
        stall_cycles = 0;
        for (int c = 0; c < 16; c++) begin
            if (stall === 1'b1) stall_cycles++;
            step();
        end
        tests_run++;
        if (stall_cycles !== 16) begin
            tests_failed++;
            $display("FAIL var_stall_hold: got %0d stalled cycles want 16", stall_cycles);
        end
        // Stray completion to an idle register changes nothing.
        comp_valid = 1'b1;
        comp_rd    = 5'd4;
        step();
        comp_valid = 1'b0;
        tests_run++;
        if (stall !== 1'b1 || outstanding !== 6'd1) begin
            tests_failed++;
            $display("FAIL var_stray_comp: got stall=%b outst=%0d want 1 1", stall, outstanding);
        end
        // Issue x10 variable while x9 completes: count unchanged.
        re = 2'b00;
        drive_issue(5'd10, 3'd7);
        comp_valid = 1'b1;
        comp_rd    = 5'd9;
        step();
        drop_issue();
        comp_valid = 1'b0;
        tests_run++;
        if (outstanding !== 6'd1) begin
            tests_failed++;
            $display("FAIL var_issue_and_comp: got %0d want 1", outstanding);
        end
        // Completion of x10 under hold: stall persists that cycle, clears next.
        re         = 2'b01;
        rs_addr    = {5'd0, 5'd10};
        hold       = 1'b1;
        comp_valid = 1'b1;
        comp_rd    = 5'd10;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL var_comp_same_cycle: got stall=%b want 1", stall);
        end
        step();
        comp_valid = 1'b0;
        hold       = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0 || outstanding !== 6'd0) begin
            tests_failed++;
            $display("FAIL var_comp_after: got stall=%b outst=%0d want 0 0", stall, outstanding);
        end
    endtask

    task automatic waw_run(input int hold_cycles, output int stalls);
        idle();
        drive_issue(5'd3, 3'd3);
        step();
        drive_issue(5'd3, 3'd0);
        stalls = 0;
        while (stalls < 20) begin
            hold = (stalls < hold_cycles) ? 1'b1 : 1'b0;
            #1;
            if (issue_fire === 1'b1) break;
            stalls++;
            step();
        end
        step();
        idle();
    endtask

    task automatic test_waw_hold();
        int stalls;
        waw_run(0, stalls);
        tests_run++;
        if (stalls !== 3) begin
            tests_failed++;
            $display("FAIL waw_stall: got %0d stall cycles want 3", stalls);
        end
        waw_run(2, stalls);
        tests_run++;
        if (stalls !== 5) begin
            tests_failed++;
            $display("FAIL waw_hold_stall: got %0d stall cycles want 5", stalls);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        drive_issue(5'd2, 3'd0);
        #1;
        tests_run++;
        if (issue_fire !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_issue_fire: got %b want 1", issue_fire);
        end
        step();
        drive_issue(5'd11, 3'd0);
        re        = 2'b10;
        rs_addr   = {5'd2, 5'd0};
        rf_data   = {32'h0000_0000, 32'h0};
        fwd_we    = 2'b01;
        fwd_waddr = {5'd0, 5'd2};
        fwd_wdata = {32'h0, 32'h0000_CAFE};
        #1;
        tests_run++;
        if (stall !== 1'b0 || issue_fire !== 1'b1 || opv[63:32] !== 32'h0000_CAFE) begin
            tests_failed++;
            $display("FAIL b2b_forward: got stall=%b fire=%b opv=%h want 0 1 0000cafe",
                     stall, issue_fire, opv[63:32]);
        end
        step();
        idle();
        tests_run++;
        if (outstanding !== 6'd0) begin
            tests_failed++;
            $display("FAIL b2b_outstanding: got %0d want 0", outstanding);
        end
    endtask

    // Sequence and report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_forward_priority();
        test_variable();
        test_waw_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
